// File: rtl/dtof_hist_pingpong_peak_pkg.sv
// Shared defaults and state encodings for the ping-pong dToF histogram block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dtof_hist_pingpong_peak_pkg;

   localparam int BIN_W_DEF   = 5;
   localparam int CNT_W_DEF   = 8;
   localparam int PIX_W_DEF   = 3;
   localparam int EVT_NUM_DEF = 2;
   localparam int ACQ_NUM_DEF = 4;

   // top FSM
   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   // scan FSM
   localparam logic [1:0] SC_IDLE = 2'd0;
   localparam logic [1:0] SC_SCAN = 2'd1;
   localparam logic [1:0] SC_EMIT = 2'd2;

   // width of a counter that runs 0..n-1 (at least one bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dtof_hist_pingpong_peak_if.sv
// Event input and peak-result output bundle of the histogram block.
// Latency: n/a (wires only).
// Backpressure: ev_* has no backpressure (ev_ready is advisory, refused events are dropped); pk_* is valid/ready.
interface dtof_hist_pingpong_peak_if
   import dtof_hist_pingpong_peak_pkg::*;
#(
   parameter int BIN_W = BIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int PIX_W = PIX_W_DEF
) ();
   logic             ev_valid;
   logic [BIN_W-1:0] ev_bin;
   logic             ev_ready;
   logic             ev_drop;
   logic             pk_valid;
   logic             pk_ready;
   logic [PIX_W-1:0] pk_pix;
   logic [BIN_W-1:0] pk_bin;
   logic [CNT_W-1:0] pk_cnt;
   logic             pk_hit;

   // master: TDC source + result consumer; slave: the histogram block
   modport master (output ev_valid, ev_bin, pk_ready,
                   input  ev_ready, ev_drop, pk_valid, pk_pix, pk_bin, pk_cnt, pk_hit);
   modport slave  (input  ev_valid, ev_bin, pk_ready,
                   output ev_ready, ev_drop, pk_valid, pk_pix, pk_bin, pk_cnt, pk_hit);
endinterface

// File: rtl/dtof_hist_pingpong_peak_hist_peak_scan.sv
// Sweeps one completed bank pixel by pixel: read-and-clear every bin, track the peak, emit one result per pixel.
// Latency: BIN_NUM+1 cycles from a pixel's scan start to pk_valid; next pixel scan starts the cycle after transfer.
// Backpressure: pk_* held stable while pk_ready=0; scanning pauses in EMIT until the result is taken.
// Ports: start/start_bank launch a sweep; rd_en/rd_addr/rd_dat is the read-and-clear RAM port; idle=no sweep running.
module hist_peak_scan
   import dtof_hist_pingpong_peak_pkg::*;
#(
   parameter int BIN_W = BIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     start,
   input  logic                     start_bank,
   input  logic [CNT_W-1:0]         thr,
   output logic                     rd_en,
   output logic [PIX_W+BIN_W:0]     rd_addr,
   input  logic [CNT_W-1:0]         rd_dat,
   output logic                     idle,
   output logic                     pk_valid,
   input  logic                     pk_ready,
   output logic [PIX_W-1:0]         pk_pix,
   output logic [BIN_W-1:0]         pk_bin,
   output logic [CNT_W-1:0]         pk_cnt,
   output logic                     pk_hit
);
   logic [1:0]       state;
   logic             bank;
   logic [PIX_W-1:0] pix;
   logic [BIN_W-1:0] bin;
   logic             rd_vld;
   logic [BIN_W-1:0] rd_bin;
   logic [CNT_W-1:0] max_cnt;
   logic [BIN_W-1:0] max_bin;
   logic [CNT_W-1:0] thr_q;
   logic             take;
   logic [CNT_W-1:0] nxt_cnt;
   logic [BIN_W-1:0] nxt_bin;

   assign rd_en   = (state == SC_SCAN);
   assign rd_addr = {bank, pix, bin};
   assign idle    = (state == SC_IDLE);

   // bin 0 always seeds the running max; strict '>' keeps the lowest bin on ties
   assign take    = rd_vld && ((rd_bin == '0) || (rd_dat > max_cnt));
   assign nxt_cnt = take ? rd_dat : max_cnt;
   assign nxt_bin = take ? rd_bin : max_bin;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state    <= SC_IDLE;
         bank     <= 1'b0;
         pix      <= '0;
         bin      <= '0;
         rd_vld   <= 1'b0;
         rd_bin   <= '0;
         max_cnt  <= '0;
         max_bin  <= '0;
         thr_q    <= '0;
         pk_valid <= 1'b0;
         pk_pix   <= '0;
         pk_bin   <= '0;
         pk_cnt   <= '0;
         pk_hit   <= 1'b0;
      end else begin
         rd_vld  <= rd_en;
         rd_bin  <= bin;
         max_cnt <= nxt_cnt;
         max_bin <= nxt_bin;
         // last bin's data lands while already in EMIT; publish the final peak then
         if (rd_vld && (rd_bin == '1)) begin
            pk_valid <= 1'b1;
            pk_pix   <= pix;
            pk_bin   <= nxt_bin;
            pk_cnt   <= nxt_cnt;
            pk_hit   <= (nxt_cnt >= thr_q);
         end
         case (state)
            SC_IDLE: if (start) begin
               bank  <= start_bank;
               pix   <= '0;
               bin   <= '0;
               thr_q <= thr;
               state <= SC_SCAN;
            end
            SC_SCAN: begin
               bin <= bin + 1'b1;
               if (bin == '1) state <= SC_EMIT;
            end
            SC_EMIT: if (pk_valid && pk_ready) begin
               pk_valid <= 1'b0;
               if (pix == '1) begin
                  state <= SC_IDLE;
               end else begin
                  pix   <= pix + 1'b1;
                  thr_q <= thr;
                  state <= SC_SCAN;
               end
            end
            default: state <= SC_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/dtof_hist_pingpong_peak.sv
// Ping-pong per-pixel dToF histogram: accumulate TDC bins into one bank while the other is peak-scanned and cleared.
// Latency: 2-cycle read-modify-write per event, 1 event/cycle; bank swap 2 cycles after the frame's last event.
// Backpressure: ev_ready=0 in INIT and while a finished frame waits for the scanner (events dropped, counted).
// Ports: clk/res clock and async active-low reset; bus = event in + peak out; thr hit threshold;
//        drop_cnt saturating drop counter; frame_done swap pulse; acc_bank bank being accumulated.
module dtof_hist_pingpong_peak
   import dtof_hist_pingpong_peak_pkg::*;
#(
   parameter int BIN_W   = BIN_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int PIX_W   = PIX_W_DEF,
   parameter int EVT_NUM = EVT_NUM_DEF,
   parameter int ACQ_NUM = ACQ_NUM_DEF
) (
   input  logic                     clk,
   input  logic                     res,
   dtof_hist_pingpong_peak_if.slave bus,
   input  logic [CNT_W-1:0]         thr,
   output logic [15:0]              drop_cnt,
   output logic                     frame_done,
   output logic                     acc_bank
);
   localparam int ADDR_W = 1 + PIX_W + BIN_W;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int EVT_W  = cnt_width(EVT_NUM);
   localparam int ACQ_W  = cnt_width(ACQ_NUM);

   logic [CNT_W-1:0]  mem [DEPTH];
   logic [1:0]        state;
   logic [ADDR_W-1:0] init_addr;
   logic [EVT_W-1:0]  evt_cnt;
   logic [PIX_W-1:0]  pix_cnt;
   logic [ACQ_W-1:0]  acq_cnt;
   logic              ev_ready, accept, drop, swap;
   logic              last_evt, last_pix, last_acq;
   logic [ADDR_W-1:0] acc_addr;
   logic              s1_vld, wb_vld;
   logic [ADDR_W-1:0] s1_addr, wb_addr;
   logic [CNT_W-1:0]  acc_rd_dat, wb_dat, acc_opnd, acc_wr_dat;
   logic              sc_en, sc_idle;
   logic [ADDR_W-1:0] sc_addr;
   logic [CNT_W-1:0]  sc_rd_dat;
   logic              ev_drop_q;

   assign ev_ready = (state == ST_RUN);
   assign accept   = bus.ev_valid && ev_ready;
   assign drop     = bus.ev_valid && !ev_ready;
   assign acc_addr = {acc_bank, pix_cnt, bus.ev_bin};
   assign last_evt = (evt_cnt == EVT_W'(EVT_NUM - 1));
   assign last_pix = (pix_cnt == '1);
   assign last_acq = (acq_cnt == ACQ_W'(ACQ_NUM - 1));
   // swap only once the final write has retired and the scanner has released the other bank
   assign swap     = (state == ST_STALL) && !s1_vld && sc_idle;

   // the RAM read of a back-to-back event to the same address misses the previous write; forward it
   assign acc_opnd   = (wb_vld && (wb_addr == s1_addr)) ? wb_dat : acc_rd_dat;
   assign acc_wr_dat = (acc_opnd == '1) ? acc_opnd : acc_opnd + 1'b1;

   assign bus.ev_ready = ev_ready;
   assign bus.ev_drop  = ev_drop_q;

   // accumulator port (init clear or RMW write) and scan port (read-and-clear) never touch the same bank
   always_ff @(posedge clk) begin
      if (state == ST_INIT) mem[init_addr] <= '0;
      else if (s1_vld)      mem[s1_addr]   <= acc_wr_dat;
      if (accept) acc_rd_dat <= mem[acc_addr];
      if (sc_en) begin
         sc_rd_dat     <= mem[sc_addr];
         mem[sc_addr]  <= '0;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state      <= ST_INIT;
         init_addr  <= '0;
         evt_cnt    <= '0;
         pix_cnt    <= '0;
         acq_cnt    <= '0;
         acc_bank   <= 1'b0;
         frame_done <= 1'b0;
         s1_vld     <= 1'b0;
         s1_addr    <= '0;
         wb_vld     <= 1'b0;
         wb_addr    <= '0;
         wb_dat     <= '0;
         ev_drop_q  <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         frame_done <= 1'b0;
         ev_drop_q  <= drop;
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
         s1_vld <= accept;
         if (accept) s1_addr <= acc_addr;
         wb_vld <= s1_vld;
         if (s1_vld) begin
            wb_addr <= s1_addr;
            wb_dat  <= acc_wr_dat;
         end
         case (state)
            ST_INIT: begin
               init_addr <= init_addr + 1'b1;
               if (init_addr == '1) state <= ST_RUN;
            end
            ST_RUN: if (accept) begin
               evt_cnt <= last_evt ? '0 : evt_cnt + 1'b1;
               if (last_evt) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  if (last_pix) begin
                     acq_cnt <= last_acq ? '0 : acq_cnt + 1'b1;
                     if (last_acq) state <= ST_STALL;
                  end
               end
            end
            ST_STALL: if (swap) begin
               acc_bank   <= ~acc_bank;
               frame_done <= 1'b1;
               state      <= ST_RUN;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   hist_peak_scan #(.BIN_W(BIN_W), .CNT_W(CNT_W), .PIX_W(PIX_W)) u_scan (
      .clk        (clk),
      .res        (res),
      .start      (swap),
      .start_bank (acc_bank),
      .thr        (thr),
      .rd_en      (sc_en),
      .rd_addr    (sc_addr),
      .rd_dat     (sc_rd_dat),
      .idle       (sc_idle),
      .pk_valid   (bus.pk_valid),
      .pk_ready   (bus.pk_ready),
      .pk_pix     (bus.pk_pix),
      .pk_bin     (bus.pk_bin),
      .pk_cnt     (bus.pk_cnt),
      .pk_hit     (bus.pk_hit)
   );
endmodule
